// File: rtl/blink_pkg.sv
// Shared definitions for the blink generator / blink decoder pair:
// pattern encodings and the common half-period count width.
package blink_pkg;

  // Width of every half-period counter on the board (generator and decoder).
  localparam int PERIOD_W = 12;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  // Classification reported by the decoder.
  typedef enum logic [1:0] {
    PAT_OFF     = 2'b00,
    PAT_ON      = 2'b01,
    PAT_BLINK   = 2'b10,
    PAT_UNKNOWN = 2'b11
  } pattern_t;

  // Increment that sticks at the top of the counter range.
  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (v == PERIOD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/blink_decoder_if.sv
// Signal bundle between the blink line / tick source and the decoder.
// The master side supplies the tick and the raw line, the slave side
// (the decoder) returns the classification.
interface blink_decoder_if;
  import blink_pkg::*;

  logic                CLK_EN;
  logic                BLINK_IN;
  pattern_t            PATTERN_O;
  logic [PERIOD_W-1:0] PERIOD_O;
  logic                CHANGE_O;

  modport master (
    output CLK_EN, BLINK_IN,
    input  PATTERN_O, PERIOD_O, CHANGE_O
  );

  modport slave (
    input  CLK_EN, BLINK_IN,
    output PATTERN_O, PERIOD_O, CHANGE_O
  );
endinterface

// File: rtl/blink_debounce.sv
// Two-flop synchronizer followed by a tick-based debounce filter.
// edge_stb is combinational and valid in the tick cycle in which the
// filtered level flips, so downstream logic can act on the same clock edge.
module blink_debounce #(
  parameter int DebounceTicks = 4
) (
  input  logic CLK_IN,
  input  logic RESET,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic edge_stb
);

  localparam logic [2:0] DEB_LAST = 3'(DebounceTicks - 1);

  logic [1:0] sync_reg;
  logic [2:0] deb_cnt_reg;
  logic       level_reg;
  logic       differ;

  // Synchronizer runs every clock, independent of the tick enable.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) sync_reg <= 2'b00;
    else       sync_reg <= {sync_reg[0], din};
  end

  assign differ   = (sync_reg[1] != level_reg);
  assign edge_stb = tick && differ && (deb_cnt_reg == DEB_LAST);

  // Count ticks the synced level disagrees with the filtered level; flip when it persisted long enough.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      deb_cnt_reg <= 3'd0;
      level_reg   <= 1'b0;
    end else if (tick) begin
      if (!differ) begin
        deb_cnt_reg <= 3'd0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        deb_cnt_reg <= 3'd0;
        level_reg   <= ~level_reg;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 3'd1;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/blink_decoder.sv
// Classifies a blink-coded status line as OFF / ON / BLINK / UNKNOWN and
// reports the last measured half-period in 1 ms ticks.
module blink_decoder
  import blink_pkg::*;
#(
  parameter int MinHalfPeriod = 400,
  parameter int MaxHalfPeriod = 600,
  parameter int SteadyTimeout = 2000,
  parameter int DebounceTicks = 4,
  parameter int LockCount     = 2
) (
  input  logic           CLK_IN,
  input  logic           RESET,
  blink_decoder_if.slave bus
);

  localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MinHalfPeriod);
  localparam logic [PERIOD_W-1:0] MAX_P    = PERIOD_W'(MaxHalfPeriod);
  localparam logic [PERIOD_W-1:0] STEADY_P = PERIOD_W'(SteadyTimeout);
  localparam logic [1:0]          LOCK_MAX = 2'(LockCount);

  logic                tick;
  logic                level;
  logic                edge_stb;
  logic [PERIOD_W-1:0] cnt_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] capture;
  logic [1:0]          lock_reg;
  logic [1:0]          lock_next;
  logic [2:0]          lock_inc;
  logic                lock_full;
  logic                in_range;
  logic                timeout;
  logic                change_reg;
  pattern_t            state_reg;
  pattern_t            state_next;

  assign tick = bus.CLK_EN;

  blink_debounce #(
    .DebounceTicks(DebounceTicks)
  ) u_debounce (
    .CLK_IN  (CLK_IN),
    .RESET   (RESET),
    .tick    (tick),
    .din     (bus.BLINK_IN),
    .level   (level),
    .edge_stb(edge_stb)
  );

  // The half-period ending on this tick, counting the edge tick itself.
  assign capture   = sat_inc(cnt_reg);
  assign in_range  = (capture >= MIN_P) && (capture <= MAX_P);
  assign lock_inc  = {1'b0, lock_reg} + 3'd1;
  assign lock_full = (lock_inc >= 3'(LockCount));
  assign lock_next = in_range ? (lock_full ? LOCK_MAX : lock_inc[1:0]) : 2'd0;
  // An edge always takes priority, so the timeout is only looked at on quiet ticks.
  assign timeout   = tick && !edge_stb && (capture == STEADY_P);

  // Half-period counter, captured period and lock counter, all advanced on ticks.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      cnt_reg    <= '0;
      period_reg <= '0;
      lock_reg   <= 2'd0;
    end else if (tick) begin
      if (edge_stb) begin
        period_reg <= capture;
        cnt_reg    <= '0;
        lock_reg   <= lock_next;
      end else begin
        cnt_reg <= capture;
        if (timeout) lock_reg <= 2'd0;
      end
    end
  end

  // Pattern state register plus a one-clock marker when the visible pattern changes.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_reg  <= PAT_UNKNOWN;
      change_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      change_reg <= (state_next != state_reg);
    end
  end

  // Next pattern: edges classify by period, quiet lines fall back to the steady level.
  always_comb begin
    state_next = state_reg;
    if (edge_stb) begin
      if (!in_range)      state_next = PAT_UNKNOWN;
      else if (lock_full) state_next = PAT_BLINK;
    end else if (timeout) begin
      state_next = level ? PAT_ON : PAT_OFF;
    end
  end

  assign bus.PATTERN_O = state_reg;
  assign bus.PERIOD_O  = period_reg;
  assign bus.CHANGE_O  = change_reg;

endmodule

// File: tb/tb_blink_decoder.sv
// Bench for blink_decoder: drives half-periods tick by tick, queues the
// pattern each driven edge should produce and compares on every CHANGE_O.
module tb_blink_decoder;
  import blink_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blink_decoder_if bus();

  blink_decoder #(
    .MinHalfPeriod(400),
    .MaxHalfPeriod(600),
    .SteadyTimeout(2000),
    .DebounceTicks(4),
    .LockCount    (2)
  ) dut (
    .CLK_IN(clk),
    .RESET (rst),
    .bus   (bus)
  );

  int         vec_cnt  = 0;
  int         miss_cnt = 0;
  int         tick_div = 1;
  logic [1:0] exp_q[$];
  logic       chg_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", tag, got, $time);
    end
  endtask

  // n ticks; each tick is tick_div clocks with CLK_EN high on the first.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.CLK_EN = 1'b1;
      @(posedge clk); #1;
      if (tick_div > 1) begin
        bus.CLK_EN = 1'b0;
        repeat (tick_div - 1) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  // Toggle the line and hold it for h ticks; the edge of this toggle has
  // been taken by the end, so PERIOD_O shows the preceding half.
  task automatic half(input int h, input int exp_period, input bit chk);
    bus.BLINK_IN = ~bus.BLINK_IN;
    run_ticks(h);
    if (chk) check("period", 32'(bus.PERIOD_O), exp_period);
  endtask

  task automatic expect_pat(input pattern_t p);
    exp_q.push_back(p);
  endtask

  // Scoreboard side: each CHANGE_O pulse consumes one expected pattern.
  always @(negedge clk) begin
    if (bus.CHANGE_O) begin
      check("chg_one_clock", 32'(chg_prev), 0);
      if (exp_q.size() == 0) check("chg_expected", 0, 1);
      else                   check("pattern_on_chg", 32'(bus.PATTERN_O), 32'(exp_q.pop_front()));
    end
    chg_prev = bus.CHANGE_O;
  end

  initial begin
    rst = 1'b1;
    bus.CLK_EN = 1'b0;
    bus.BLINK_IN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pattern", 32'(bus.PATTERN_O), 3);
    check("reset_period", 32'(bus.PERIOD_O), 0);
    check("reset_change", 32'(bus.CHANGE_O), 0);
    rst = 1'b0;

    // Clean blink, tick every 10 clocks, half-period 501.
    tick_div = 10;
    half(501, 5, 1);
    half(501, 501, 1);
    expect_pat(PAT_BLINK);
    half(501, 501, 1);
    check("clean_blink", 32'(bus.PATTERN_O), 2);

    // Back-to-back ticks from here; the switch adds one tick of latency.
    tick_div = 1;
    half(300, 502, 1);
    check("still_blink", 32'(bus.PATTERN_O), 2);
    expect_pat(PAT_UNKNOWN);
    half(500, 300, 1);
    check("short_half_unknown", 32'(bus.PATTERN_O), 3);
    half(500, 500, 1);
    check("lock_cleared", 32'(bus.PATTERN_O), 3);
    expect_pat(PAT_BLINK);
    half(400, 500, 1);
    check("relock", 32'(bus.PATTERN_O), 2);

    // Range boundaries: 400 holds BLINK, 601 rejects, 400 + 600 relock.
    half(601, 400, 1);
    check("min_bound_blink", 32'(bus.PATTERN_O), 2);
    expect_pat(PAT_UNKNOWN);
    half(400, 601, 1);
    check("over_max_unknown", 32'(bus.PATTERN_O), 3);
    half(600, 400, 1);
    expect_pat(PAT_BLINK);
    half(500, 600, 1);
    check("max_bound_blink", 32'(bus.PATTERN_O), 2);

    // Reset in the middle of a blink at an odd clock phase.
    half(500, 500, 1);
    bus.BLINK_IN = 1'b1;
    run_ticks(123);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_pattern", 32'(bus.PATTERN_O), 3);
    check("midrst_period", 32'(bus.PERIOD_O), 0);
    check("midrst_change", 32'(bus.CHANGE_O), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_ticks(50);
    check("post_rst_edge", 32'(bus.PERIOD_O), 6);
    half(500, 50, 1);
    half(500, 500, 1);
    check("post_rst_one_lock", 32'(bus.PATTERN_O), 3);
    expect_pat(PAT_BLINK);
    half(500, 500, 1);
    check("post_rst_relock", 32'(bus.PATTERN_O), 2);

    // Hold high from reset: ON exactly 2000 ticks after the only edge.
    rst = 1'b1;
    bus.BLINK_IN = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_ticks(2005);
    check("hold_first_edge", 32'(bus.PERIOD_O), 6);
    check("hold_before_timeout", 32'(bus.PATTERN_O), 3);
    expect_pat(PAT_ON);
    run_ticks(1);
    check("hold_at_timeout", 32'(bus.PATTERN_O), 1);
    check("hold_change", 32'(bus.CHANGE_O), 1);
    run_ticks(994);
    check("hold_stays_on", 32'(bus.PATTERN_O), 1);

    // 3-tick glitch is filtered out.
    bus.BLINK_IN = 1'b0;
    run_ticks(3);
    bus.BLINK_IN = 1'b1;
    run_ticks(10);
    check("glitch_period", 32'(bus.PERIOD_O), 6);
    check("glitch_pattern", 32'(bus.PATTERN_O), 1);

    // 4-tick pulse makes two edges; the second captures 4.
    expect_pat(PAT_UNKNOWN);
    bus.BLINK_IN = 1'b0;
    run_ticks(4);
    bus.BLINK_IN = 1'b1;
    run_ticks(10);
    check("pulse_period", 32'(bus.PERIOD_O), 4);
    check("pulse_pattern", 32'(bus.PATTERN_O), 3);

    // Quiet again: ON at the timeout, then a low level ends in OFF.
    run_ticks(1995);
    check("quiet_pre_timeout", 32'(bus.PATTERN_O), 3);
    expect_pat(PAT_ON);
    run_ticks(1);
    check("quiet_on", 32'(bus.PATTERN_O), 1);
    expect_pat(PAT_UNKNOWN);
    bus.BLINK_IN = 1'b0;
    run_ticks(6);
    check("after_steady_period", 32'(bus.PERIOD_O), 2006);
    check("after_steady_unknown", 32'(bus.PATTERN_O), 3);
    expect_pat(PAT_OFF);
    run_ticks(2000);
    check("low_off", 32'(bus.PATTERN_O), 0);
    check("low_off_change", 32'(bus.CHANGE_O), 1);
    run_ticks(3);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
